dpram_param: RTL and testbench

- Parametrised dual-port RAM: one write port, one read port, single clock.
- Generalises the fixed 16x8 DPRAM with:
  - configurable data width and depth
  - byte-enable writes
  - selectable read latency
  - defined read/write collision policy
  - hardware memory-initialisation sweep with busy flag
- Sits behind the bus/testbench driver; read data feeds downstream datapath or output monitor.

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_init_fsm.sv | 58 +++++
 rtl/dpram_param.sv | 130 +++++++++++++
 tb/tb_dpram_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } dpram_state_e;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } coll_mode_e;

    // Number of byte lanes for a given data width.
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dpram_init_fsm.sv
// Init-sweep controller: walks every address once after reset or clr and
// refuses user accesses while the sweep is running.
module dpram_init_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              init_busy,
    output logic              access_err,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    dpram_state_e      state_reg;
    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= INIT;
            addr_reg   <= '0;
            init_busy  <= 1'b1;
            access_err <= 1'b0;
        end else begin
            access_err <= init_busy && (wr_en || rd_en);
            case (state_reg)
                INIT: begin
                    if (clr) begin
                        addr_reg <= '0;
                    end else if (addr_reg == {ADDR_W{1'b1}}) begin
                        // Last word is written on this edge; open for traffic next cycle.
                        state_reg <= IDLE;
                        addr_reg  <= '0;
                        init_busy <= 1'b0;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state_reg <= INIT;
                        addr_reg  <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    assign init_we   = (state_reg == INIT) && !reset;
    assign init_addr = addr_reg;

endmodule

// File: rtl/dpram_param.sv
// Parametrised 1W/1R RAM with byte enables, 1- or 2-cycle read latency,
// selectable same-address collision policy and a hardware init sweep.
module dpram_param
    import dpram_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 4,
    parameter int               RD_LAT    = 1,
    parameter int               COLL_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int              BE_W      = be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              init_busy,
    output logic              access_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit WF    = (COLL_MODE == int'(WRITE_FIRST));

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    dpram_init_fsm #(
        .ADDR_W(ADDR_W)
    ) u_init_fsm (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .init_busy (init_busy),
        .access_err(access_err),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic              user_we;
    logic              rd_fire;
    logic              fwd_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] rd_word;
    logic              v1_reg;

    assign user_we = wr_en && !init_busy && !reset;
    assign rd_fire = rd_en && !init_busy;
    assign fwd_hit = WF && user_we && (wr_addr == rd_addr);

    // Sweep and user writes are mutually exclusive, so one write port serves both.
    assign mem_we    = init_we || user_we;
    assign mem_addr  = init_we ? init_addr : wr_addr;
    assign mem_wdata = init_we ? INIT_VAL : data_in;
    assign mem_be    = init_we ? {BE_W{1'b1}} : wr_be;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (mem_we && mem_be[gi]) begin
                    lane_mem[mem_addr] <= mem_wdata[gi*8 +: 8];
                end
            end

            // Array read register; in write-first mode an enabled byte is bypassed.
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_rd_reg <= '0;
                end else if (rd_fire) begin
                    if (fwd_hit && wr_be[gi]) begin
                        lane_rd_reg <= data_in[gi*8 +: 8];
                    end else begin
                        lane_rd_reg <= lane_mem[rd_addr];
                    end
                end
            end

            assign rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg <= 1'b0;
        end else begin
            v1_reg <= rd_fire;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] out_reg;
            logic              v2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_reg <= '0;
                    v2_reg  <= 1'b0;
                end else begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        out_reg <= rd_word;
                    end
                end
            end

            assign data_out = out_reg;
            assign rd_valid = v2_reg;
        end else begin : g_lat1
            assign data_out = rd_word;
            assign rd_valid = v1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// Two RAM configurations driven with shared stimulus and checked against a
// per-cycle behavioural model of the memory, init sweep and read schedule.
module tb_dpram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s = 1'b1;
    logic        clr_s = 1'b0;
    logic        we_s  = 1'b0;
    logic [3:0]  wa_s  = '0;
    logic [1:0]  be_s  = '0;
    logic [15:0] din_s = '0;
    logic        re_s  = 1'b0;
    logic [3:0]  ra_s  = '0;

    logic [7:0]  dout_a;
    logic        val_a, busy_a, err_a;
    logic [15:0] dout_b;
    logic        val_b, busy_b, err_b;

    // A: 8-bit, latency 1, read-first, init 0. B: 16-bit, latency 2, write-first, init 5A3C.
    dpram_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .COLL_MODE(0), .INIT_VAL(8'h00)) u_a (
        .clk(clk), .reset(rst_s), .clr(clr_s), .wr_en(we_s), .wr_addr(wa_s),
        .wr_be(be_s[0:0]), .data_in(din_s[7:0]), .rd_en(re_s), .rd_addr(ra_s),
        .data_out(dout_a), .rd_valid(val_a), .init_busy(busy_a), .access_err(err_a)
    );

    dpram_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .COLL_MODE(1), .INIT_VAL(16'h5A3C)) u_b (
        .clk(clk), .reset(rst_s), .clr(clr_s), .wr_en(we_s), .wr_addr(wa_s),
        .wr_be(be_s), .data_in(din_s), .rd_en(re_s), .rd_addr(ra_s),
        .data_out(dout_b), .rd_valid(val_b), .init_busy(busy_b), .access_err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state
    int          LAT [2]  = '{1, 2};
    bit          WFM [2]  = '{1'b0, 1'b1};
    logic [15:0] IVAL[2]  = '{16'h0000, 16'h5A3C};
    logic [15:0] MASK[2]  = '{16'h00FF, 16'hFFFF};
    logic [15:0] m_mem [2][16];
    int          busy_cnt[2];
    int          ptr[2];
    bit          exp_err[2];
    bit          due_v[2][4];
    logic [15:0] due_d[2][4];
    logic [15:0] exp_dout[2];

    task automatic model_edge(input int i);
        logic [1:0]  bei;
        logic [15:0] wr_new, rd_res;
        if (rst_s) begin
            busy_cnt[i] = 16;
            ptr[i]      = 0;
            exp_err[i]  = 1'b0;
            exp_dout[i] = '0;
            for (int s = 0; s < 4; s++) due_v[i][s] = 1'b0;
        end else begin
            exp_err[i] = (busy_cnt[i] != 0) && (we_s || re_s);
            if (busy_cnt[i] != 0) begin
                m_mem[i][ptr[i]] = IVAL[i];
                if (clr_s) begin
                    ptr[i] = 0;
                    busy_cnt[i] = 16;
                end else begin
                    ptr[i]++;
                    busy_cnt[i]--;
                end
            end else begin
                bei = (i == 0) ? {1'b0, be_s[0]} : be_s;
                wr_new = m_mem[i][wa_s];
                for (int b = 0; b < 2; b++)
                    if (bei[b]) wr_new[b*8 +: 8] = din_s[b*8 +: 8];
                if (re_s) begin
                    rd_res = (WFM[i] && we_s && (wa_s == ra_s)) ? wr_new : m_mem[i][ra_s];
                    due_v[i][(cyc + LAT[i] - 1) % 4] = 1'b1;
                    due_d[i][(cyc + LAT[i] - 1) % 4] = rd_res & MASK[i];
                end
                if (we_s) m_mem[i][wa_s] = wr_new;
                if (clr_s) begin
                    busy_cnt[i] = 16;
                    ptr[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        bit ev;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            ev = due_v[i][cyc % 4];
            if (ev) begin
                exp_dout[i] = due_d[i][cyc % 4];
                due_v[i][cyc % 4] = 1'b0;
                $display("cycle %0d inst%0d read done, expect %h", cyc, i, exp_dout[i]);
            end
            check_val($sformatf("busy%0d", i), (i == 0) ? busy_a : busy_b, busy_cnt[i] != 0);
            check_val($sformatf("err%0d", i), (i == 0) ? err_a : err_b, exp_err[i]);
            check_val($sformatf("valid%0d", i), (i == 0) ? val_a : val_b, ev);
            check_val($sformatf("dout%0d", i), (i == 0) ? {8'h00, dout_a} : dout_b, exp_dout[i]);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit w, input logic [3:0] wa,
                         input logic [1:0] be, input logic [15:0] d, input bit re,
                         input logic [3:0] ra);
        rst_s = r; clr_s = c; we_s = w; wa_s = wa; be_s = be; din_s = d; re_s = re; ra_s = ra;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and full init sweep, then read every address.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(16);
        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 0, 0, 1, 4'(a));
        idle(2);

        // Simple write then read.
        drive(0, 0, 1, 4'd3, 2'b11, 16'h00A5, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd3);
        idle(3);

        // Byte-enable merge.
        drive(0, 0, 1, 4'd5, 2'b11, 16'h1234, 0, 0);
        drive(0, 0, 1, 4'd5, 2'b01, 16'hABCD, 0, 0);
        drive(0, 0, 1, 4'd6, 2'b00, 16'hFFFF, 1, 4'd5);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd6);
        idle(3);

        // Same-address collision.
        drive(0, 0, 1, 4'd7, 2'b11, 16'h0011, 0, 0);
        drive(0, 0, 1, 4'd7, 2'b11, 16'h0077, 1, 4'd7);
        drive(0, 0, 1, 4'd8, 2'b10, 16'hBEEF, 1, 4'd8);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd7);
        idle(3);

        // clr sweep with a refused write and read during it.
        drive(0, 0, 1, 4'd2, 2'b11, 16'h0055, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 4'd2);
        drive(0, 0, 1, 4'd2, 2'b11, 16'h0099, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd2);
        idle(15);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd2);
        idle(3);

        // Back-to-back reads with reset mid-stream.
        drive(0, 0, 1, 4'd1, 2'b11, 16'hC3C3, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd1);
        drive(1, 0, 0, 0, 0, 0, 1, 4'd2);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd3);
        idle(17);

        // Randomised traffic with occasional clr and reset.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)),
                  16'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? wa : 4'($urandom_range(0, 15)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
